// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
// Optional overflow saturation is enabled by defining BCD_SCHED_OVF_EN.
package bcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [7:0] BCD_MAX = 8'd99;
    localparam logic [7:0] BCD_SAT = 8'h99;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               vld_o
);

    function automatic int slot(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[slot(ptr_i, k)]) begin
                gnt_o                 = '0;
                gnt_o[slot(ptr_i, k)] = 1'b1;
                idx_o                 = ID_W'(slot(ptr_i, k));
                vld_o                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one external binary-to-BCD engine among NUM_REQ requesters.
// Define BCD_SCHED_OVF_EN to add rsp_ovf and saturate results of operands above 99.
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ENG_LAT = 10,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic [7:0]           eng_din,
    output logic                 eng_din_vld,
    input  logic [7:0]           eng_bcd,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [7:0]           rsp_bcd,
    output logic [ID_W-1:0]      rsp_id,
`ifdef BCD_SCHED_OVF_EN
    output logic                 rsp_ovf,
`endif
    output logic                 busy
);

    localparam int CNT_W = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]     idx_q, idx_d, ptr_q, ptr_d, id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          din_q, din_d, bcd_q, bcd_d;
`ifdef BCD_SCHED_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_vld;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (req_vld),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        din_d       = din_q;
        bcd_d       = bcd_q;
        id_d        = id_q;
`ifdef BCD_SCHED_OVF_EN
        ovf_d       = ovf_q;
`endif
        req_rdy     = '0;
        eng_din_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                    din_d   = req_data[{arb_idx, 3'b000} +: 8];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                req_rdy     = gnt_q;
                eng_din_vld = 1'b1;
                ptr_d       = (idx_q == ID_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                cnt_d       = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                // Engine output is only trusted once the full latency has elapsed.
                if (cnt_q == CNT_W'(ENG_LAT - 1)) begin
                    cnt_d   = '0;
                    id_d    = idx_q;
                    state_d = RESP;
`ifdef BCD_SCHED_OVF_EN
                    ovf_d   = (din_q > BCD_MAX);
                    bcd_d   = (din_q > BCD_MAX) ? BCD_SAT : eng_bcd;
`else
                    bcd_d   = eng_bcd;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            bcd_q   <= '0;
            id_q    <= '0;
`ifdef BCD_SCHED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            bcd_q   <= bcd_d;
            id_q    <= id_d;
`ifdef BCD_SCHED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign eng_din = din_q;
    assign rsp_vld = (state_q == RESP);
    assign rsp_bcd = bcd_q;
    assign rsp_id  = id_q;
    assign busy    = (state_q != IDLE);
`ifdef BCD_SCHED_OVF_EN
    assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched with a serial shift-add-3 engine model on the eng_* port.
module tb_bcd_conv_sched;

    localparam int NUM_REQ = 4;
    localparam int ENG_LAT = 10;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NUM_REQ-1:0]   req_vld = '0;
    logic [NUM_REQ*8-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_rdy;
    logic [7:0]           eng_din;
    logic                 eng_din_vld;
    logic [7:0]           eng_bcd = 8'h00;
    logic                 rsp_vld;
    logic                 rsp_rdy = 1'b1;
    logic [7:0]           rsp_bcd;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;
`ifdef BCD_SCHED_OVF_EN
    logic                 rsp_ovf;
    logic                 rq_ovf[$];
`endif

    int n_cmp = 0;
    int n_err = 0;
    int gq[$];
    int rq_id[$];
    logic [7:0] rq_bcd[$];

    always #5 clk = ~clk;

    bcd_conv_sched #(.NUM_REQ(NUM_REQ), .ENG_LAT(ENG_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_rdy     (req_rdy),
        .eng_din     (eng_din),
        .eng_din_vld (eng_din_vld),
        .eng_bcd     (eng_bcd),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_bcd     (rsp_bcd),
        .rsp_id      (rsp_id),
`ifdef BCD_SCHED_OVF_EN
        .rsp_ovf     (rsp_ovf),
`endif
        .busy        (busy)
    );

    // Engine: load, 8 double-dabble shifts, capture; output is junk while converting.
    logic [7:0] e_bin = 8'h00;
    logic [7:0] e_acc = 8'h00;
    int         e_cnt = 0;
    logic       e_pend = 1'b0;

    function automatic logic [7:0] dd_step(input logic [7:0] a, input logic b);
        logic [7:0] t;
        t = a;
        if (t[3:0] >= 4'd5) t[3:0] = t[3:0] + 4'd3;
        if (t[7:4] >= 4'd5) t[7:4] = t[7:4] + 4'd3;
        return {t[6:0], b};
    endfunction

    always @(posedge clk) begin
        if (eng_din_vld) begin
            e_bin   <= eng_din;
            e_acc   <= 8'h00;
            e_cnt   <= 8;
            e_pend  <= 1'b1;
            eng_bcd <= 8'hEE;
        end else if (e_cnt > 0) begin
            e_acc <= dd_step(e_acc, e_bin[7]);
            e_bin <= e_bin << 1;
            e_cnt <= e_cnt - 1;
        end else if (e_pend) begin
            eng_bcd <= e_acc;
            e_pend  <= 1'b0;
        end
    end

    // Expected response from the operand value alone.
    function automatic logic [7:0] ref_bcd(input int v);
`ifdef BCD_SCHED_OVF_EN
        if (v > 99) return 8'h99;
`endif
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic clear_q();
        gq.delete();
        rq_id.delete();
        rq_bcd.delete();
`ifdef BCD_SCHED_OVF_EN
        rq_ovf.delete();
`endif
    endtask

    // Inputs seen now are what the next posedge sees, so handshakes are logged before advancing.
    task automatic tick();
        if (rsp_vld === 1'b1 && rsp_rdy) begin
            rq_id.push_back(int'(rsp_id));
            rq_bcd.push_back(rsp_bcd);
`ifdef BCD_SCHED_OVF_EN
            rq_ovf.push_back(rsp_ovf);
`endif
        end
        for (int i = 0; i < NUM_REQ; i++)
            if (req_rdy[i] === 1'b1) begin
                gq.push_back(i);
                req_vld[i] = 1'b0;
            end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int d);
        req_data[8*i +: 8] = 8'(d);
        req_vld[i] = 1'b1;
    endtask

    task automatic run_rsp(input int n, input int budget);
        int k;
        k = 0;
        while (rq_id.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic do_reset();
        req_vld = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (req_rdy !== '0) begin n_err++; $display("FAIL reset_req_rdy got=%b exp=0", req_rdy); end
        n_cmp++; if (eng_din !== 8'h00) begin n_err++; $display("FAIL reset_eng_din got=%h exp=00", eng_din); end
        n_cmp++; if (eng_din_vld !== 1'b0) begin n_err++; $display("FAIL reset_eng_din_vld got=%b exp=0", eng_din_vld); end
        n_cmp++; if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL reset_rsp_vld got=%b exp=0", rsp_vld); end
        n_cmp++; if (rsp_bcd !== 8'h00) begin n_err++; $display("FAIL reset_rsp_bcd got=%h exp=00", rsp_bcd); end
        n_cmp++; if (rsp_id !== '0) begin n_err++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int kr, kv, nr;
        logic [NUM_REQ-1:0] gv;
        kr = -1; kv = -1; nr = 0; gv = '0;
        do_reset();
        set_req(0, 57);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (req_rdy !== '0) begin nr++; if (kr < 0) begin kr = k; gv = req_rdy; end end
            if (rsp_vld === 1'b1 && kv < 0) kv = k;
        end
        n_cmp++; if (kr != 1) begin n_err++; $display("FAIL single_grant_cycle got=%0d exp=1", kr); end
        n_cmp++; if (gv !== 4'b0001) begin n_err++; $display("FAIL single_grant_vec got=%b exp=0001", gv); end
        n_cmp++; if (nr != 1) begin n_err++; $display("FAIL single_grant_width got=%0d exp=1", nr); end
        n_cmp++; if (kv != ENG_LAT + 2) begin n_err++; $display("FAIL single_rsp_latency got=%0d exp=%0d", kv, ENG_LAT + 2); end
        n_cmp++;
        if (rq_bcd.size() != 1 || rq_bcd[0] !== 8'h57 || rq_id[0] != 0) begin
            n_err++; $display("FAIL single_rsp n=%0d bcd=%h id=%0d exp n=1 bcd=57 id=0",
                              rq_bcd.size(), rq_bcd.size() ? rq_bcd[0] : 8'h00, rq_id.size() ? rq_id[0] : -1);
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_all_four();
        int d[4];
        d = '{12, 34, 56, 78};
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, d[i]);
        run_rsp(4, 100);
        n_cmp++; if (rq_id.size() != 4) begin n_err++; $display("FAIL all4_count got=%0d exp=4", rq_id.size()); end
        for (int i = 0; i < 4 && i < rq_id.size() && i < gq.size(); i++) begin
            n_cmp++;
            if (gq[i] != i || rq_id[i] != i || rq_bcd[i] !== ref_bcd(d[i])) begin
                n_err++; $display("FAIL all4_slot%0d grant=%0d id=%0d bcd=%h exp grant=%0d id=%0d bcd=%h",
                                  i, gq[i], rq_id[i], rq_bcd[i], i, i, ref_bcd(d[i]));
            end
        end
    endtask

    task automatic test_wrap();
        clear_q();
        set_req(0, 3);
        set_req(3, 80);
        run_rsp(2, 60);
        n_cmp++;
        if (gq.size() != 2 || gq[0] != 0 || gq[1] != 3) begin
            n_err++; $display("FAIL wrap_1001 n=%0d g0=%0d g1=%0d exp 0,3", gq.size(),
                              gq.size() > 0 ? gq[0] : -1, gq.size() > 1 ? gq[1] : -1);
        end
        n_cmp++;
        if (rq_bcd.size() != 2 || rq_bcd[0] !== 8'h03 || rq_bcd[1] !== 8'h80) begin
            n_err++; $display("FAIL wrap_data n=%0d exp 03,80", rq_bcd.size());
        end
        clear_q();
        set_req(2, 5);
        run_rsp(1, 40);
        clear_q();
        set_req(0, 1);
        set_req(1, 99);
        run_rsp(2, 60);
        n_cmp++;
        if (gq.size() != 2 || gq[0] != 0 || gq[1] != 1) begin
            n_err++; $display("FAIL wrap_from3 n=%0d g0=%0d g1=%0d exp 0,1", gq.size(),
                              gq.size() > 0 ? gq[0] : -1, gq.size() > 1 ? gq[1] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        int k, nbad;
        clear_q();
        rsp_rdy = 1'b0;
        set_req(0, 37);
        tick();
        tick();
        set_req(1, 91);
        k = 0;
        while (rsp_vld !== 1'b1 && k < 30) begin tick(); k++; end
        n_cmp++; if (rsp_vld !== 1'b1) begin n_err++; $display("FAIL bp_rsp_timeout got=%b exp=1", rsp_vld); end
        held = rsp_bcd;
        nbad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_vld !== 1'b1 || rsp_bcd !== held || req_rdy !== '0 || eng_din_vld !== 1'b0 || busy !== 1'b1)
                nbad++;
        end
        n_cmp++; if (nbad != 0) begin n_err++; $display("FAIL bp_stall bad_cycles=%0d exp=0", nbad); end
        n_cmp++; if (held !== 8'h37 || rsp_id !== 2'd0) begin n_err++; $display("FAIL bp_held bcd=%h id=%0d exp bcd=37 id=0", held, rsp_id); end
        rsp_rdy = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (req_rdy !== 4'b0010 || eng_din_vld !== 1'b1) begin
            n_err++; $display("FAIL bp_release_launch rdy=%b vld=%b exp rdy=0010 vld=1", req_rdy, eng_din_vld);
        end
        run_rsp(2, 40);
        n_cmp++;
        if (rq_bcd.size() != 2 || rq_bcd[1] !== 8'h91 || rq_id[1] != 1) begin
            n_err++; $display("FAIL bp_second_rsp n=%0d exp bcd=91 id=1", rq_bcd.size());
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_q();
        set_req(2, 45);
        for (int c = 0; c < 5; c++) tick();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({req_rdy, eng_din, eng_din_vld, rsp_vld, rsp_bcd, rsp_id, busy} !== '0) begin
            n_err++; $display("FAIL midreset_outputs rdy=%b din=%h dv=%b rv=%b bcd=%h id=%0d busy=%b exp all 0",
                              req_rdy, eng_din, eng_din_vld, rsp_vld, rsp_bcd, rsp_id, busy);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin tick(); if (rsp_vld !== 1'b0) seen++; end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midreset_ghost_rsp cycles=%0d exp=0", seen); end
        clear_q();
        set_req(0, 9);
        run_rsp(1, 40);
        n_cmp++;
        if (rq_bcd.size() != 1 || rq_bcd[0] !== 8'h09 || rq_id[0] != 0) begin
            n_err++; $display("FAIL midreset_fresh n=%0d exp bcd=09 id=0", rq_bcd.size());
        end
    endtask

    task automatic test_operand_gt99();
        clear_q();
        set_req(1, 200);
        run_rsp(1, 40);
        set_req(2, 99);
        run_rsp(2, 40);
        n_cmp++; if (rq_bcd.size() != 2) begin n_err++; $display("FAIL gt99_count got=%0d exp=2", rq_bcd.size()); end
`ifdef BCD_SCHED_OVF_EN
        n_cmp++;
        if (rq_bcd.size() > 0 && (rq_bcd[0] !== 8'h99 || rq_ovf[0] !== 1'b1)) begin
            n_err++; $display("FAIL ovf_200 bcd=%h ovf=%b exp bcd=99 ovf=1", rq_bcd[0], rq_ovf[0]);
        end
        n_cmp++;
        if (rq_bcd.size() > 1 && (rq_bcd[1] !== 8'h99 || rq_ovf[1] !== 1'b0)) begin
            n_err++; $display("FAIL ovf_99 bcd=%h ovf=%b exp bcd=99 ovf=0", rq_bcd[1], rq_ovf[1]);
        end
`else
        n_cmp++;
        if (rq_bcd.size() > 0 && rq_bcd[0] !== 8'h00) begin
            n_err++; $display("FAIL raw_200 bcd=%h exp=00", rq_bcd[0]);
        end
        n_cmp++;
        if (rq_bcd.size() > 1 && rq_bcd[1] !== 8'h99) begin
            n_err++; $display("FAIL raw_99 bcd=%h exp=99", rq_bcd[1]);
        end
`endif
    endtask

    task automatic test_random();
        int mptr, pat, rem, c, k;
        int exp_g[$];
        int dat[NUM_REQ];
        do_reset();
        mptr = 0;
        for (int b = 0; b < 25; b++) begin
            clear_q();
            exp_g.delete();
            pat = int'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                dat[i] = int'($urandom_range(0, 255));
                if (pat[i]) set_req(i, dat[i]);
            end
            rem = pat;
            while (rem != 0) begin
                for (int o = 0; o < NUM_REQ; o++) begin
                    c = (mptr + o) % NUM_REQ;
                    if (rem[c]) begin
                        exp_g.push_back(c);
                        rem = rem & ~(1 << c);
                        mptr = (c + 1) % NUM_REQ;
                        break;
                    end
                end
            end
            k = 0;
            while (rq_id.size() < exp_g.size() && k < 400) begin
                rsp_rdy = ($urandom_range(0, 3) != 0);
                tick();
                k++;
            end
            rsp_rdy = 1'b1;
            n_cmp++;
            if (rq_id.size() != exp_g.size()) begin
                n_err++; $display("FAIL rand_b%0d_count got=%0d exp=%0d", b, rq_id.size(), exp_g.size());
            end
            for (int j = 0; j < exp_g.size() && j < rq_id.size() && j < gq.size(); j++) begin
                n_cmp++;
                if (gq[j] != exp_g[j] || rq_id[j] != exp_g[j] || rq_bcd[j] !== ref_bcd(dat[exp_g[j]])) begin
                    n_err++; $display("FAIL rand_b%0d_r%0d grant=%0d id=%0d bcd=%h exp id=%0d bcd=%h",
                                      b, j, gq[j], rq_id[j], rq_bcd[j], exp_g[j], ref_bcd(dat[exp_g[j]]));
                end
`ifdef BCD_SCHED_OVF_EN
                n_cmp++;
                if (rq_ovf[j] !== (dat[exp_g[j]] > 99)) begin
                    n_err++; $display("FAIL rand_b%0d_r%0d_ovf got=%b exp=%b", b, j, rq_ovf[j], dat[exp_g[j]] > 99);
                end
`endif
            end
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_operand_gt99();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
